// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, frame RAM geometry and fetch FSM states.
//   No ports. Imported by vga_timing_gen and vga_ram_reader.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int LINE_BITS = 320;
    localparam int ROWS      = 240;
    localparam int CNT_W     = 10;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {IDLE, WAIT, LATCH} fetch_state_t;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA hcount/vcount counters with raw (unregistered) sync and enable.
//   clk, rst         : pixel clock, synchronous active-high reset
//   o_hcount/vcount  : current beam position
//   o_hsync/o_vsync  : active-low sync decoded from the counters
//   o_de             : high while the counters are in the visible area
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de
);
    localparam logic [CNT_W-1:0] C_H_VIS   = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] C_HS_BEG  = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] C_HS_END  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] C_V_VIS   = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] C_VS_BEG  = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] C_VS_END  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h, r_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= (r_h == C_H_LAST) ? '0 : r_h + 1'b1;
            if (r_h == C_H_LAST) r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
        end
    end

    assign o_hcount = r_h;
    assign o_vcount = r_v;
    assign o_hsync  = !(r_h >= C_HS_BEG && r_h < C_HS_END);
    assign o_vsync  = !(r_v >= C_VS_BEG && r_v < C_VS_END);
    assign o_de     = (r_h < C_H_VIS) && (r_v < C_V_VIS);
endmodule

// File: rtl/vga_ram_reader.sv
// vga_ram_reader: VGA scan-out of a 1bpp frame RAM, each RAM row/bit doubled to 2x2 screen pixels.
//   clk, rst        : pixel clock (also RAM read clock), synchronous active-high reset
//   i_ram_data      : RAM row, bit LINE_BITS-1 is the leftmost pixel
//   o_ram_address   : RAM row address, updated at hcount == H_VISIBLE of the line before use
//   o_ram_clk       : clk passed straight through to the RAM
//   o_hsync/o_vsync : active-low syncs, o_de display enable, o_pixel mono pixel (all registered)
//   Optional: define VGA_RAM_READER_BORDER_EN to force a 1-pixel white frame border.
module vga_ram_reader
    import vga_pkg::*;
#(
    parameter int H_VISIBLE   = vga_pkg::H_VISIBLE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int LINE_BITS   = vga_pkg::LINE_BITS,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LINE_BITS-1:0] i_ram_data,
    output logic [ADDR_W-1:0]    o_ram_address,
    output logic                 o_ram_clk,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic                 o_pixel
);
    localparam logic [CNT_W-1:0] C_H_VIS     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] C_H_LAST    = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] C_V_VIS     = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] C_V_LAST    = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [1:0]       C_WAIT_LAST = 2'(RAM_LATENCY - 1);

    logic [CNT_W-1:0]     w_hcount, w_vcount, w_tgt_v;
    logic                 w_hsync, w_vsync, w_de, w_tgt_vis, w_start, w_border;
    fetch_state_t         r_state, w_next;
    logic [1:0]           r_wait;
    logic [LINE_BITS-1:0] r_line, r_shift;

    vga_timing_gen #(
        .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .o_hcount(w_hcount), .o_vcount(w_vcount),
        .o_hsync(w_hsync), .o_vsync(w_vsync), .o_de(w_de)
    );

    assign o_ram_clk = clk;
    // The row fetched during this line's hblank is displayed on the next line.
    assign w_tgt_v   = (w_vcount == C_V_LAST) ? '0 : w_vcount + 1'b1;
    assign w_tgt_vis = w_tgt_v < C_V_VIS;
    assign w_start   = (w_hcount == C_H_VIS) && w_tgt_vis;

`ifdef VGA_RAM_READER_BORDER_EN
    localparam logic [CNT_W-1:0] C_H_EDGE = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] C_V_EDGE = CNT_W'(V_VISIBLE - 1);
    assign w_border = (w_hcount == '0) || (w_hcount == C_H_EDGE) || (w_vcount == '0) || (w_vcount == C_V_EDGE);
`else
    assign w_border = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_start) w_next = WAIT;
        if (r_state == WAIT && r_wait == C_WAIT_LAST) w_next = LATCH;
        if (r_state == LATCH) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == WAIT) ? r_wait + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ram_address <= '0;
            r_line        <= '0;
            r_shift       <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_de          <= 1'b0;
            o_pixel       <= 1'b0;
        end else begin
            if (w_start) o_ram_address <= ADDR_W'(w_tgt_v >> 1);
            if (r_state == LATCH) r_line <= i_ram_data;
            // Each bit is held for two clocks: shift only after odd hcounts.
            if (w_hcount == C_H_LAST) r_shift <= w_tgt_vis ? r_line : '0;
            else if (w_de && w_hcount[0]) r_shift <= r_shift << 1;
            o_hsync <= w_hsync;
            o_vsync <= w_vsync;
            o_de    <= w_de;
            o_pixel <= w_de && (w_border || r_shift[LINE_BITS-1]);
        end
    end
endmodule

// File: tb/tb_vga_ram_reader.sv
// tb_vga_ram_reader: reduced-geometry bench driving RAM_LATENCY=1 and =4 instances against a beam-position model.
module tb_vga_ram_reader;
    localparam int LB = 8, HV = 16, HFP = 2, HS = 4, HBP = 4, HT = HV + HFP + HS + HBP;
    localparam int VV = 8, VFP = 1, VS = 1, VBP = 2, VT = VV + VFP + VS + VBP, ROWS = VV / 2;

    logic clk = 1'b0, rst = 1'b1;
    logic [LB-1:0] mem [ROWS];
    logic [7:0] a1, a4, p1;
    logic [7:0] p4 [4];
    logic [LB-1:0] d1, d4;
    logic rc1, rc4, hs1, vs1, de1, px1, hs4, vs4, de4, px4;
    int mh, mv, exp_addr, pass_cnt, total_cnt, n_hs, n_vs, n_de, n_pix;
    bit wrapped;

    always #5 clk = ~clk;

    // Synchronous RAM models: data follows the address 1 or 4 clocks later.
    always @(posedge clk) begin
        p1    <= a1;
        p4[0] <= a4;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign d1 = mem[p1[1:0]];
    assign d4 = mem[p4[3][1:0]];

    vga_ram_reader #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LINE_BITS(LB), .RAM_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst), .i_ram_data(d1), .o_ram_address(a1), .o_ram_clk(rc1),
        .o_hsync(hs1), .o_vsync(vs1), .o_de(de1), .o_pixel(px1)
    );

    vga_ram_reader #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LINE_BITS(LB), .RAM_LATENCY(4)
    ) dut4 (
        .clk(clk), .rst(rst), .i_ram_data(d4), .o_ram_address(a4), .o_ram_clk(rc4),
        .o_hsync(hs4), .o_vsync(vs4), .o_de(de4), .o_pixel(px4)
    );

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt += 2;
            if ({a1, hs1, vs1, de1, px1} !== 12'b0000_0000_1100)
                $display("FAIL %s dut1 {addr,hs,vs,de,px} got %b want 000000001100", tag, {a1, hs1, vs1, de1, px1});
            else pass_cnt++;
            if ({a4, hs4, vs4, de4, px4} !== 12'b0000_0000_1100)
                $display("FAIL %s dut4 {addr,hs,vs,de,px} got %b want 000000001100", tag, {a4, hs4, vs4, de4, px4});
            else pass_cnt++;
        end
        rst = 1'b0;
        mh = 0;
        mv = 0;
        exp_addr = 0;
        wrapped = 1'b0;
    endtask

    // Every clock: expected outputs follow directly from the beam position of the previous clock.
    task automatic scan(input int n, input string tag);
        logic [11:0] e;
        logic [LB-1:0] row;
        logic ep;
        int tgt;
        n_hs = 0;
        n_vs = 0;
        n_de = 0;
        n_pix = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            tgt = (mv == VT - 1) ? 0 : mv + 1;
            if (mh == HV && tgt < VV) exp_addr = tgt / 2;
            ep = 1'b0;
            if (mh < HV && mv < VV) begin
                row = mem[mv / 2];
                ep = (mv != 0 || wrapped) ? row[LB - 1 - mh / 2] : 1'b0;
`ifdef VGA_RAM_READER_BORDER_EN
                if (mh == 0 || mh == HV - 1 || mv == 0 || mv == VV - 1) ep = 1'b1;
`endif
            end
            e = {8'(exp_addr), !(mh >= HV + HFP && mh < HV + HFP + HS),
                 !(mv >= VV + VFP && mv < VV + VFP + VS), (mh < HV && mv < VV), ep};
            #1;
            total_cnt += 2;
            if ({a1, hs1, vs1, de1, px1} !== e)
                $display("FAIL %s dut1 h=%0d v=%0d {addr,hs,vs,de,px} got %b want %b", tag, mh, mv, {a1, hs1, vs1, de1, px1}, e);
            else pass_cnt++;
            if ({a4, hs4, vs4, de4, px4} !== e)
                $display("FAIL %s dut4 h=%0d v=%0d {addr,hs,vs,de,px} got %b want %b", tag, mh, mv, {a4, hs4, vs4, de4, px4}, e);
            else pass_cnt++;
            n_hs += int'(!hs1);
            n_vs += int'(!vs1);
            n_de += int'(de1);
            n_pix += int'(px1);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) begin
                    mv = 0;
                    wrapped = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total_cnt++;
        if (rc1 !== 1'b1 || rc4 !== 1'b1) $display("FAIL ram_clk_high got %b%b want 11", rc1, rc4);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (rc1 !== 1'b0 || rc4 !== 1'b0) $display("FAIL ram_clk_low got %b%b want 00", rc1, rc4);
        else pass_cnt++;
        for (int r = 0; r < ROWS; r++) mem[r] = 8'(r + 1);
        apply_reset("reset_powerup");
        scan(2 * HT, "reset_restart");
    endtask

    task automatic test_pattern();
        for (int r = 0; r < ROWS; r++) mem[r] = 8'hAA;
        apply_reset("reset_pattern");
        scan(2 * HT * VT, "pattern");
        total_cnt += 3;
        if (n_hs != 2 * HS * VT) $display("FAIL hsync_low_count got %0d want %0d", n_hs, 2 * HS * VT);
        else pass_cnt++;
        if (n_vs != 2 * VS * HT) $display("FAIL vsync_low_count got %0d want %0d", n_vs, 2 * VS * HT);
        else pass_cnt++;
        if (n_de != 2 * HV * VV) $display("FAIL de_count got %0d want %0d", n_de, 2 * HV * VV);
        else pass_cnt++;
`ifndef VGA_RAM_READER_BORDER_EN
        total_cnt++;
        if (n_pix != (2 * VV - 1) * HV / 2) $display("FAIL pattern_ones got %0d want %0d", n_pix, (2 * VV - 1) * HV / 2);
        else pass_cnt++;
`endif
    endtask

    task automatic test_row_mapping();
        for (int r = 0; r < ROWS; r++) begin
            logic [1:0] rb;
            rb = 2'(r);
            mem[r] = {rb[0], 6'($urandom), rb[1]};
        end
        apply_reset("reset_rowmap");
        scan(2 * HT * VT, "row_mapping");
    endtask

    task automatic test_random();
        for (int r = 0; r < ROWS; r++) mem[r] = 8'($urandom);
        apply_reset("reset_random");
        scan(2 * HT * VT, "random_rows");
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < ROWS; r++) mem[r] = 8'($urandom);
        apply_reset("reset_pre_mid");
        scan(HT * VT + 5 * HT + 7, "before_mid_reset");
        apply_reset("reset_mid_frame");
        scan(2 * HT * VT, "after_mid_reset");
    endtask

`ifdef VGA_RAM_READER_BORDER_EN
    task automatic test_border();
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        apply_reset("reset_border");
        scan(HT * VT, "border");
        total_cnt++;
        if (n_pix != 2 * HV + 2 * (VV - 2)) $display("FAIL border_count got %0d want %0d", n_pix, 2 * HV + 2 * (VV - 2));
        else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_pattern();
        test_row_mapping();
        test_random();
        test_mid_reset();
`ifdef VGA_RAM_READER_BORDER_EN
        test_border();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
